ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the scancode FIFO entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 SHALL have port nextdata_n  input  1  active-low pop request from the downstream scancode lookup (MuxKey decode).
REQ-008 SHALL have port data  output  8  scancode at the FIFO head.
REQ-009 SHALL have port ready  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse when a frame is dropped for bad parity.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers, and SHALL detect a falling edge when the two oldest ps2_clk stages equal 2'b10.
REQ-013 SHALL sample synchronized ps2_data on each detected falling edge into an 11-bit frame, LSB first: start, D0..D7, parity, stop.
REQ-014 SHALL hold a 4-bit bit counter that counts 0..10, increments per edge, and returns to 0 after the 11th edge.
REQ-015 SHALL treat a frame as valid on the 11th edge when start==0, stop==1, and (with REQ-030) XOR of D0..D7 and parity equals 1.
REQ-016 SHALL push a valid frame's D7..D0 into the FIFO in the 11th-edge cycle; ready and data SHALL reflect it from the next cycle.
REQ-017 SHALL drop invalid frames silently unless REQ-030 applies; the bit counter still returns to 0.
REQ-018 SHALL drive data combinationally from the FIFO head entry; data is don't-care while ready==0.
REQ-019 SHALL pop one entry on every clk edge where nextdata_n==0 and ready==1; a pop on an empty FIFO SHALL be ignored with no pointer change.
REQ-020 SHALL evaluate push and pop in the same cycle; when full, a simultaneous pop frees the slot and the push SHALL be accepted, with the count unchanged.
REQ-021 SHALL, on a push while full without a pop, discard the byte, leave the FIFO unchanged, and set overflow to 1 until reset.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH, and SHALL use an extra pointer bit to distinguish full from empty.
REQ-023 SHALL count idle clk cycles while the bit counter is non-zero; on reaching TIMEOUT_CYCLES it SHALL reset the bit counter to 0 and discard the partial frame with no FIFO effect.
REQ-024 SHALL clear the timeout counter on every detected falling edge and whenever the bit counter is 0.

Reset
REQ-025 SHALL, while rst_n==0 at a clk edge, clear the FIFO pointers, bit counter, timeout counter and frame shift register, and set the synchronizers to all-ones (idle-high).
REQ-026 SHALL drive reset outputs as: ready=0, overflow=0, parity_err=0, data=8'h00.
REQ-027 SHALL abandon any frame in progress when reset is asserted mid-frame; a frame resumed after reset is not reassembled.
REQ-028 SHALL leave FIFO storage contents uninitialized, since they are unobservable while ready==0.

Configuration
REQ-029 SHALL use the macro PS2_PARITY_CHECK_EN.
REQ-030 SHALL, with PS2_PARITY_CHECK_EN defined, include the odd-parity check in frame validity and pulse parity_err for one cycle on a frame with good start/stop but bad parity.
REQ-031 SHALL, with PS2_PARITY_CHECK_EN undefined, ignore the parity bit for validity and tie parity_err to 0.

Verification
REQ-032 SHALL cover: frame 0x1C (bits 0,00111000,0,1) -> ready=1 and data=8'h1C one cycle after the 11th edge; nextdata_n low for 1 cycle -> ready=0.
REQ-033 SHALL cover: with the macro defined, frame 0x1C sent with parity bit 1 -> parity_err pulses once and ready stays 0; with the macro undefined -> data=8'h1C.
REQ-034 SHALL cover: 9 valid frames 0x01..0x09 with no pops, FIFO_DEPTH=8 -> overflow=1; then 8 pops return 0x01..0x08 in order and ready=0.
REQ-035 SHALL cover: FIFO full, with the 11th edge of 0x55 coinciding with nextdata_n=0 -> head popped, 0x55 accepted, overflow stays 0.
REQ-036 SHALL cover: 5 bits of a frame then TIMEOUT_CYCLES idle cycles, then a complete frame 0xF0 -> only 0xF0 is queued.
REQ-037 SHALL cover: rst_n pulsed low after the 6th edge of a frame -> all outputs at reset values, and the next full frame 0x32 is received correctly.

Source files
------------

// File: rtl/ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_keyboard
//   PS/2 keyboard receiver. It synchronizes the device clock and data lines,
//   assembles 11-bit frames (start, D0..D7, parity, stop) on ps2_clk falling
//   edges, and queues valid scancodes in a small FIFO for a downstream
//   scancode lookup.
//
// Parameters
//   FIFO_DEPTH     : scancode FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES : clk cycles without a ps2_clk falling edge before a
//                    partially received frame is abandoned
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   ps2_clk    in   PS/2 device clock (asynchronous)
//   ps2_data   in   PS/2 device data (asynchronous)
//   nextdata_n in   active-low pop request
//   data       out  scancode at FIFO head (8'h00 while empty)
//   ready      out  FIFO non-empty
//   overflow   out  sticky: a valid frame was dropped on a full FIFO
//   parity_err out  one-cycle pulse when a frame is dropped for bad parity
//
// Configuration macro
//   PS2_PARITY_CHECK_EN : when defined, odd parity is part of frame validity
//                         and parity_err is generated; otherwise the parity
//                         bit is ignored and parity_err is tied low.
// ---------------------------------------------------------------------------
module ps2_keyboard #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       parity_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]    clk_sync_reg;
   logic [2:0]    data_sync_reg;
   logic          fall_edge;
   logic [3:0]    bit_cnt_reg;
   logic [9:0]    frame_reg;
   logic [10:0]   frame_next;
   logic [TW-1:0] timeout_cnt_reg;
   logic          frame_done;
   logic          framing_ok;
   logic          parity_ok;
   logic          frame_valid;
   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic [7:0]    mem [FIFO_DEPTH];
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          overflow_reg;
   logic          parity_err_reg;

   // Three-stage synchronizers; reset to idle-high so leaving reset
   // never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_reg  <= 3'b111;
         data_sync_reg <= 3'b111;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
         data_sync_reg <= {data_sync_reg[1:0], ps2_data};
      end
   end

   assign fall_edge = (clk_sync_reg[2:1] == 2'b10);

   // Bits arrive LSB first: shift in at the top so that after the 11th
   // edge bit 0 holds the start bit and bit 10 the stop bit.
   assign frame_next = {data_sync_reg[2], frame_reg};
   assign frame_done = fall_edge && (bit_cnt_reg == 4'd10);
   assign framing_ok = !frame_next[0] && frame_next[10];

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^frame_next[9:1];
`else
   assign parity_ok = 1'b1;
`endif

   assign frame_valid = framing_ok && parity_ok;
   assign push        = frame_done && frame_valid;

   // Frame assembly with inter-edge timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt_reg     <= 4'd0;
         frame_reg       <= 10'd0;
         timeout_cnt_reg <= '0;
      end else if (fall_edge) begin
         frame_reg       <= frame_next[10:1];
         timeout_cnt_reg <= '0;
         bit_cnt_reg     <= (bit_cnt_reg == 4'd10) ? 4'd0 : bit_cnt_reg + 4'd1;
      end else if (bit_cnt_reg == 4'd0) begin
         timeout_cnt_reg <= '0;
      end else if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
         // Device stalled mid-frame: throw the partial frame away.
         bit_cnt_reg     <= 4'd0;
         frame_reg       <= 10'd0;
         timeout_cnt_reg <= '0;
      end else begin
         timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
      end
   end

   // FIFO: the extra pointer MSB separates full from empty.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop        = !nextdata_n && !fifo_empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push_ok    = push && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         overflow_reg   <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !push_ok) overflow_reg <= 1'b1;
         parity_err_reg <= frame_done && framing_ok && !parity_ok;
      end
   end

   // Storage is not reset; it is only visible while ready is high.
   always_ff @(posedge clk) begin
      if (rst_n && push_ok) mem[wr_ptr_reg[AW-1:0]] <= frame_next[8:1];
   end

   always_comb begin
      data = 8'h00;
      if (!fifo_empty) data = mem[rd_ptr_reg[AW-1:0]];
   end

   assign ready      = !fifo_empty;
   assign overflow   = overflow_reg;
`ifdef PS2_PARITY_CHECK_EN
   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
module tb_ps2_keyboard;

   localparam int DEPTH = 8;
   localparam int TMO   = 4096;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       parity_err;

   int n_cmp = 0;
   int n_err = 0;
   int perr_seen = 0;
   int perr_exp = 0;
   int half = 5;

   // Reference model: a queue of scancodes plus a sticky overflow flag.
   logic [7:0] mdl_q[$];
   logic       mdl_ovf = 1'b0;

   always #5 clk = ~clk;

   ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .parity_err (parity_err)
   );

   always @(posedge clk) if (rst_n && parity_err) perr_seen++;

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                              input logic bad_stop);
      return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".ready"}, 32'(ready), 32'(mdl_q.size() != 0));
      if (mdl_q.size() != 0) check({tag, ".data"}, 32'(data), 32'(mdl_q[0]));
      check({tag, ".ovf"}, 32'(overflow), 32'(mdl_ovf));
      check({tag, ".perr"}, perr_seen, perr_exp);
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         cyc(half);
         ps2_clk = 1'b0;
         cyc(half);
         ps2_clk = 1'b1;
      end
      cyc(2);
   endtask

   // Frame validity from the protocol rules, then queue semantics.
   task automatic model_frame(input logic [10:0] f);
      logic ss;
      logic valid;
      ss = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      valid = ss && (^f[9:1]);
      if (ss && !(^f[9:1])) perr_exp++;
`else
      valid = ss;
`endif
      if (valid) begin
         if (mdl_q.size() < DEPTH) mdl_q.push_back(f[8:1]);
         else mdl_ovf = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic [10:0] f;
      f = make_frame(b, bad_par, bad_stop);
      half = $urandom_range(4, 7);
      send_bits(f, 11);
      model_frame(f);
      $display("frame %02h bad_par=%0d bad_stop=%0d ready=%0d data=%02h", b, bad_par, bad_stop,
               ready, data);
      check_state($sformatf("frame_%02h", b));
   endtask

   task automatic pop_once();
      nextdata_n = 1'b0;
      cyc(1);
      nextdata_n = 1'b1;
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      $display("pop ready=%0d data=%02h", ready, data);
      check_state("pop");
   endtask

   task automatic do_reset(input int n);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst_n    = 1'b0;
      cyc(n);
      check("rst.ready", 32'(ready), 32'd0);
      check("rst.ovf", 32'(overflow), 32'd0);
      check("rst.perr", 32'(parity_err), 32'd0);
      check("rst.data", 32'(data), 32'h00);
      rst_n = 1'b1;
      mdl_q.delete();
      mdl_ovf = 1'b0;
      cyc(2);
      $display("reset ready=%0d ovf=%0d", ready, overflow);
   endtask

   task automatic drain();
      while (mdl_q.size() > 0) pop_once();
   endtask

   initial begin
      logic [10:0] f;
      cyc(1);
      do_reset(3);

      // Basic reception and pop
      send_frame(8'h1C, 1'b0, 1'b0);
      pop_once();

      // Bad parity: dropped with pulse, or accepted when parity is ignored
      send_frame(8'h1C, 1'b1, 1'b0);
      drain();

      // Partial frame abandoned by timeout, then a clean frame
      half = 5;
      send_bits(make_frame(8'hA7, 1'b0, 1'b0), 5);
      cyc(TMO + 20);
      check("timeout.ready", 32'(ready), 32'd0);
      send_frame(8'hF0, 1'b0, 1'b0);
      pop_once();

      // Overflow on the ninth frame, then ordered read-back
      for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) pop_once();

      // Full FIFO with a pop coinciding with the push of 0x55
      do_reset(2);
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b0);
      f = make_frame(8'h55, 1'b0, 1'b0);
      half = 5;
      send_bits(f, 10);
      ps2_data = f[10];
      cyc(half);
      ps2_clk = 1'b0;
      cyc(2);
      nextdata_n = 1'b0;
      cyc(1);
      nextdata_n = 1'b1;
      cyc(half - 3);
      ps2_clk = 1'b1;
      cyc(2);
      void'(mdl_q.pop_front());
      model_frame(f);
      $display("frame 55 with pop ready=%0d data=%02h ovf=%0d", ready, data, overflow);
      check_state("coincide");
      check("coincide.ovf0", 32'(overflow), 32'd0);
      drain();

      // Reset in the middle of a frame
      half = 5;
      send_bits(make_frame(8'($urandom), 1'b0, 1'b0), 6);
      do_reset(2);
      send_frame(8'h32, 1'b0, 1'b0);
      pop_once();

      // Randomized mix of frames and pops
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 9) < 6)
            send_frame(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
         else
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) pop_once();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
